// File: rtl/va_sweep_seq.sv
// Frequency sweep sequencer driven by the HPS va_gen_sm PIO command word.
// State | meaning: IDLE wait for RUN | LOAD set first point | SETTLE dwell | MEAS await meas_ack | STEP next point.
module va_sweep_seq #(
    parameter int FREQ_W    = 24,
    parameter int CNT_W     = 16,
    parameter int DWELL_W   = 20,
    parameter int DWELL_RST = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       cmd_word,
    input  logic              meas_ack,
    output logic [FREQ_W-1:0] freq_code,
    output logic              freq_valid,
    output logic              meas_req,
    output logic [CNT_W-1:0]  point_idx,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cmd_ack
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_MEAS   = 3'd3,
        S_STEP   = 3'd4
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_START = 3'd1;
    localparam logic [2:0] OP_STEP  = 3'd2;
    localparam logic [2:0] OP_COUNT = 3'd3;
    localparam logic [2:0] OP_DWELL = 3'd4;
    localparam logic [2:0] OP_RUN   = 3'd5;
    localparam logic [2:0] OP_ABORT = 3'd6;

    state_t             state_q, state_d;
    logic               tog_q, prev_tog_q, prev_tog_d;
    logic [2:0]         op_q;
    logic [23:0]        pay_q;
    logic               ack_q, ack_d;
    logic [FREQ_W-1:0]  start_q, start_d, step_q, step_d, freq_q, freq_d;
    logic [CNT_W-1:0]   count_q, count_d, idx_q, idx_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d, dcnt_q, dcnt_d;
    logic               fv_q, fv_d, req_q, req_d, busy_q, busy_d;
    logic               done_q, done_d, err_q, err_d;
    logic               new_cmd;
    logic               unused_rsvd;

    // Bits 27:24 of the command word carry nothing.
    assign unused_rsvd = ^cmd_word[27:24];
    assign new_cmd     = tog_q ^ prev_tog_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Previous toggle mirrors the live word so reset never fakes a command.
            tog_q      <= cmd_word[31];
            prev_tog_q <= cmd_word[31];
            op_q       <= OP_NOP;
            pay_q      <= '0;
            ack_q      <= 1'b0;
            start_q    <= '0;
            step_q     <= '0;
            count_q    <= '0;
            dwell_q    <= DWELL_W'(DWELL_RST);
            dcnt_q     <= '0;
            state_q    <= S_IDLE;
            freq_q     <= '0;
            fv_q       <= 1'b0;
            req_q      <= 1'b0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            tog_q      <= cmd_word[31];
            prev_tog_q <= prev_tog_d;
            op_q       <= cmd_word[30:28];
            pay_q      <= cmd_word[23:0];
            ack_q      <= ack_d;
            start_q    <= start_d;
            step_q     <= step_d;
            count_q    <= count_d;
            dwell_q    <= dwell_d;
            dcnt_q     <= dcnt_d;
            state_q    <= state_d;
            freq_q     <= freq_d;
            fv_q       <= fv_d;
            req_q      <= req_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        prev_tog_d = tog_q;
        ack_d      = ack_q ^ new_cmd;
        start_d    = start_q;
        step_d     = step_q;
        count_d    = count_q;
        dwell_d    = dwell_q;
        dcnt_d     = dcnt_q;
        freq_d     = freq_q;
        fv_d       = 1'b0;
        req_d      = req_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;

        case (state_q)
            S_LOAD: begin
                freq_d  = start_q;
                idx_d   = '0;
                fv_d    = 1'b1;
                dcnt_d  = dwell_q;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (dcnt_q == '0) begin
                    req_d   = 1'b1;
                    state_d = S_MEAS;
                end else begin
                    dcnt_d = dcnt_q - DWELL_W'(1);
                end
            end
            S_MEAS: begin
                if (meas_ack) begin
                    req_d = 1'b0;
                    if (idx_q == count_q - CNT_W'(1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_STEP;
                    end
                end
            end
            S_STEP: begin
                freq_d  = freq_q + step_q;
                idx_d   = idx_q + CNT_W'(1);
                fv_d    = 1'b1;
                dcnt_d  = dwell_q;
                state_d = S_SETTLE;
            end
            default: ;
        endcase

        // Command decode runs last so ABORT overrides whatever the sweep was doing.
        if (new_cmd) begin
            case (op_q)
                OP_START, OP_STEP, OP_COUNT, OP_DWELL: begin
                    if (busy_q) begin
                        err_d = 1'b1;
                    end else begin
                        case (op_q)
                            OP_START: start_d = pay_q[FREQ_W-1:0];
                            OP_STEP:  step_d  = pay_q[FREQ_W-1:0];
                            OP_COUNT: count_d = pay_q[CNT_W-1:0];
                            default:  dwell_d = pay_q[DWELL_W-1:0];
                        endcase
                    end
                end
                OP_RUN: begin
                    if (busy_q || count_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_LOAD;
                    end
                end
                OP_ABORT: begin
                    if (busy_q) begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                        busy_d  = 1'b0;
                        fv_d    = 1'b0;
                        done_d  = done_q;
                        freq_d  = freq_q;
                        idx_d   = idx_q;
                    end
                end
                OP_NOP: ;
                default: err_d = 1'b1;
            endcase
        end
    end

    assign freq_code  = freq_q;
    assign freq_valid = fv_q;
    assign meas_req   = req_q;
    assign point_idx  = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign cmd_ack    = ack_q;

endmodule
